// File: rtl/pc_ctrl_pkg.sv
// Shared types and helpers for the PC redirect controller.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'b00,
        RUN      = 2'b01,
        REDIRECT = 2'b10,
        HALT     = 2'b11
    } pc_state_e;

    localparam int PC_STEP = 4;

    // A redirect target is usable only if word aligned and inside the PC_W-bit address space.
    function automatic logic target_ok(input logic [31:0] tgt, input int unsigned pc_w);
        return (tgt[1:0] == 2'b00) && ((tgt >> pc_w) == 32'd0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Program counter owner and fetch sequencer for the 5-stage core.
// Optional statistics counters are enabled with `define PC_REDIRECT_STATS_EN.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int             PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int             CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             stall,
    input  logic             halt_req,
    output logic [PC_W-1:0]  PC,
    output logic             if_valid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic             tgt_fault
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [CNT_W-1:0] br_redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic            valid_c, fl_ifid_c, fl_idex_c;
    logic            br_accept, stall_evt;
    logic            tgt_good;

    assign tgt_good = target_ok(BrPC, PC_W);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        valid_c   = 1'b0;
        fl_ifid_c = 1'b0;
        fl_idex_c = 1'b0;
        br_accept = 1'b0;
        stall_evt = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                valid_c = !stall;
                if (PcSel) begin
                    fl_ifid_c = 1'b1;
                    fl_idex_c = 1'b1;
                    if (tgt_good) begin
                        pc_d      = BrPC[PC_W-1:0];
                        br_accept = 1'b1;
                        state_d   = halt_req ? HALT : REDIRECT;
                    end else begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end else if (halt_req) begin
                    fl_ifid_c = 1'b1;
                    state_d   = HALT;
                end else if (stall) begin
                    stall_evt = 1'b1;
                end else begin
                    pc_d = pc_q + PC_W'(PC_STEP);
                end
            end
            REDIRECT: begin
                // The EX slot holds a bubble here, so PcSel carries no real request.
                valid_c = !stall;
                state_d = RUN;
                if (halt_req) begin
                    fl_ifid_c = 1'b1;
                    state_d   = HALT;
                end else if (stall) begin
                    stall_evt = 1'b1;
                end else begin
                    pc_d = pc_q + PC_W'(PC_STEP);
                end
            end
            HALT: fl_ifid_c = 1'b1;
            default: state_d = BOOT;
        endcase
    end

    // While reset is asserted every output is forced quiet and PC shows the reset vector.
    assign PC         = reset ? pc_q : RESET_PC;
    assign if_valid   = reset & valid_c;
    assign flush_ifid = reset & fl_ifid_c;
    assign flush_idex = reset & fl_idex_c;
    assign halted     = reset & (state_q == HALT);
    assign tgt_fault  = reset & fault_q;

`ifdef PC_REDIRECT_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, stall_cnt_q;

    sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (br_accept),
        .cnt   (br_cnt_q)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_evt),
        .cnt   (stall_cnt_q)
    );

    assign br_redirect_cnt = reset ? br_cnt_q : '0;
    assign stall_cnt       = reset ? stall_cnt_q : '0;
`else
    logic unused_stats;
    assign unused_stats = br_accept ^ stall_evt ^ (CNT_W > 0);
`endif

endmodule
